// File: rtl/scan_decoder_if.sv
// Control/status bundle for scan_decoder: select, enable group, scan controls and decoded outputs.
// Signal suffixes are relative to the decoder: _i drives into it, _o comes out of it.
interface scan_decoder_if #(
  parameter int AW      = 3,
  parameter int DWELL_W = 8
);
  logic [AW-1:0]      a_i;
  logic [3:1]         e_i;
  logic               mode_i;
  logic               start_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [2**AW-1:0]   o_o;
  logic [AW-1:0]      idx_o;
  logic               busy_o;
  logic               wrap_o;

  modport master (
    output a_i, e_i, mode_i, start_i, dwell_i,
    input  o_o, idx_o, busy_o, wrap_o
  );

  modport slave (
    input  a_i, e_i, mode_i, start_i, dwell_i,
    output o_o, idx_o, busy_o, wrap_o
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered AW-to-2**AW one-hot decoder with direct and autonomous scan modes.
// Define SCAN_DECODER_ACTIVE_LOW_EN for inverted (74x138-style) select outputs.
module scan_decoder #(
  parameter int AW      = 3,
  parameter int DWELL_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  scan_decoder_if.slave bus
);
  localparam int N = 2**AW;

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       sel_q, sel_d;
  logic [AW-1:0]      idx_q, idx_d, idx_inc;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               wrap_q, wrap_d;
  logic               en;
  logic               start_ok;

  function automatic logic [N-1:0] onehot(input logic [AW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign en       = bus.e_i[3] & ~bus.e_i[2] & ~bus.e_i[1];
  assign start_ok = bus.mode_i & bus.start_i & en;
  assign idx_inc  = idx_q + AW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok)     state_d = ST_SCAN;
      ST_SCAN: if (!bus.mode_i)  state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_d   = sel_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.mode_i) begin
          sel_d = en ? onehot(bus.a_i) : '0;
          idx_d = bus.a_i;
        end else if (start_ok) begin
          sel_d   = onehot(bus.a_i);
          idx_d   = bus.a_i;
          cnt_d   = bus.dwell_i;
          dwell_d = bus.dwell_i;
        end
      end
      ST_SCAN: begin
        if (!bus.mode_i || !en) begin
          sel_d = '0;
        end else if (sel_q == '0) begin
          // Leaving a pause: restore the held line before counting again.
          sel_d = onehot(idx_q);
        end else if (cnt_q == '0) begin
          idx_d  = idx_inc;
          sel_d  = onehot(idx_inc);
          cnt_d  = dwell_q;
          wrap_d = (idx_q == AW'(N - 1));
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: sel_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  assign bus.o_o = ~sel_q;
`else
  assign bus.o_o = sel_q;
`endif
  assign bus.idx_o  = idx_q;
  assign bus.busy_o = (state_q == ST_SCAN);
  assign bus.wrap_o = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed-vector bench for scan_decoder (AW=3, DWELL_W=8); honours SCAN_DECODER_ACTIVE_LOW_EN.
module tb_scan_decoder;
  localparam int AW = 3;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  scan_decoder_if #(.AW(AW), .DWELL_W(DW)) bus ();
  scan_decoder #(.AW(AW), .DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.a_i = 3'd3; bus.e_i = 3'b100; bus.mode_i = 1'b0;
    bus.start_i = 1'b0; bus.dwell_i = 8'd0;
    #12;
    vectors++;
    if ({bus.o_o, bus.idx_o, bus.busy_o, bus.wrap_o} !== {pol(8'h00), 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: o=%h idx=%0d busy=%b wrap=%b, want o=%h idx=0 busy=0 wrap=0",
               bus.o_o, bus.idx_o, bus.busy_o, bus.wrap_o, pol(8'h00));
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.o_o !== pol(8'h00)) begin
      miscompares++;
      $display("FAIL release_no_toggle: o=%h, want %h", bus.o_o, pol(8'h00));
    end
    tick();
    vectors++;
    if ({bus.o_o, bus.idx_o} !== {pol(8'h08), 3'd3}) begin
      miscompares++;
      $display("FAIL first_edge_decode: o=%h idx=%0d, want o=%h idx=3", bus.o_o, bus.idx_o, pol(8'h08));
    end
  endtask

  task automatic test_direct();
    logic [2:0] a_t [5] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd7};
    logic [2:0] e_t [5] = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b111};
    logic [7:0] o_t [5] = '{8'h01, 8'h02, 8'h00, 8'h04, 8'h00};
    bus.mode_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.a_i = a_t[i]; bus.e_i = e_t[i];
      tick();
      vectors++;
      if ({bus.o_o, bus.idx_o, bus.busy_o} !== {pol(o_t[i]), a_t[i], 1'b0}) begin
        miscompares++;
        $display("FAIL direct[%0d]: o=%h idx=%0d busy=%b, want o=%h idx=%0d busy=0",
                 i, bus.o_o, bus.idx_o, bus.busy_o, pol(o_t[i]), a_t[i]);
      end
    end
  endtask

  task automatic test_scan_wrap();
    logic [7:0] o_t [9] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01};
    logic [2:0] i_t [9] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0};
    logic       w_t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.e_i = 3'b100; bus.mode_i = 1'b1; bus.a_i = 3'd6; bus.dwell_i = 8'd2; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 1) bus.dwell_i = 8'd0;
      if (i == 4) begin bus.start_i = 1'b1; bus.a_i = 3'd1; end
      if (i == 5) bus.start_i = 1'b0;
      vectors++;
      if ({bus.o_o, bus.idx_o, bus.busy_o, bus.wrap_o} !== {pol(o_t[i]), i_t[i], 1'b1, w_t[i]}) begin
        miscompares++;
        $display("FAIL scan_wrap[%0d]: o=%h idx=%0d busy=%b wrap=%b, want o=%h idx=%0d busy=1 wrap=%b",
                 i, bus.o_o, bus.idx_o, bus.busy_o, bus.wrap_o, pol(o_t[i]), i_t[i], w_t[i]);
      end
      tick();
    end
    vectors++;
    if ({bus.o_o, bus.idx_o} !== {pol(8'h02), 3'd1}) begin
      miscompares++;
      $display("FAIL scan_after_wrap: o=%h idx=%0d, want o=%h idx=1", bus.o_o, bus.idx_o, pol(8'h02));
    end
    bus.mode_i = 1'b0;
    tick();
    vectors++;
    if ({bus.o_o, bus.idx_o, bus.busy_o, bus.wrap_o} !== {pol(8'h00), 3'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL scan_stop: o=%h idx=%0d busy=%b wrap=%b, want o=%h idx=1 busy=0 wrap=0",
               bus.o_o, bus.idx_o, bus.busy_o, bus.wrap_o, pol(8'h00));
    end
    tick();
    vectors++;
    if ({bus.o_o, bus.idx_o} !== {pol(8'h02), 3'd1}) begin
      miscompares++;
      $display("FAIL direct_after_stop: o=%h idx=%0d, want o=%h idx=1", bus.o_o, bus.idx_o, pol(8'h02));
    end
  endtask

  task automatic test_pause_stop();
    bit seen;
    bus.e_i = 3'b100; bus.mode_i = 1'b1; bus.a_i = 3'd2; bus.dwell_i = 8'd2; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    vectors++;
    if ({bus.o_o, bus.idx_o} !== {pol(8'h08), 3'd3}) begin
      miscompares++;
      $display("FAIL pause_setup: o=%h idx=%0d, want o=%h idx=3", bus.o_o, bus.idx_o, pol(8'h08));
    end
    bus.e_i = 3'b110;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({bus.o_o, bus.idx_o, bus.busy_o} !== {pol(8'h00), 3'd3, 1'b1}) begin
        miscompares++;
        $display("FAIL paused[%0d]: o=%h idx=%0d busy=%b, want o=%h idx=3 busy=1",
                 i, bus.o_o, bus.idx_o, bus.busy_o, pol(8'h00));
      end
    end
    bus.e_i = 3'b100;
    tick();
    vectors++;
    if ({bus.o_o, bus.idx_o, bus.busy_o} !== {pol(8'h08), 3'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL resume: o=%h idx=%0d busy=%b, want o=%h idx=3 busy=1",
               bus.o_o, bus.idx_o, bus.busy_o, pol(8'h08));
    end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (bus.idx_o == 3'd4) seen = 1'b1;
    end
    vectors++;
    if (!seen || bus.o_o !== pol(8'h10)) begin
      miscompares++;
      $display("FAIL resume_count: o=%h idx=%0d, want o=%h idx=4 within 4 cycles",
               bus.o_o, bus.idx_o, pol(8'h10));
    end
    bus.mode_i = 1'b0;
    tick();
    vectors++;
    if ({bus.o_o, bus.idx_o, bus.busy_o} !== {pol(8'h00), 3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL pause_then_stop: o=%h idx=%0d busy=%b, want o=%h idx=4 busy=0",
               bus.o_o, bus.idx_o, bus.busy_o, pol(8'h00));
    end
  endtask

  task automatic test_reset_mid_scan();
    bus.e_i = 3'b100; bus.mode_i = 1'b1; bus.a_i = 3'd4; bus.dwell_i = 8'd0; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    vectors++;
    if ({bus.o_o, bus.idx_o, bus.busy_o} !== {pol(8'h20), 3'd5, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset_scan: o=%h idx=%0d busy=%b, want o=%h idx=5 busy=1",
               bus.o_o, bus.idx_o, bus.busy_o, pol(8'h20));
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.o_o, bus.idx_o, bus.busy_o, bus.wrap_o} !== {pol(8'h00), 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: o=%h idx=%0d busy=%b wrap=%b, want o=%h idx=0 busy=0 wrap=0",
               bus.o_o, bus.idx_o, bus.busy_o, bus.wrap_o, pol(8'h00));
    end
    bus.mode_i = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_edge_cases();
    logic [7:0] o_t [3] = '{8'h80, 8'h01, 8'h02};
    logic       w_t [3] = '{1'b0, 1'b1, 1'b0};
    bus.e_i = 3'b100; bus.mode_i = 1'b1; bus.a_i = 3'd7; bus.dwell_i = 8'd0; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.o_o, bus.busy_o, bus.wrap_o} !== {pol(o_t[i]), 1'b1, w_t[i]}) begin
        miscompares++;
        $display("FAIL dwell0[%0d]: o=%h busy=%b wrap=%b, want o=%h busy=1 wrap=%b",
                 i, bus.o_o, bus.busy_o, bus.wrap_o, pol(o_t[i]), w_t[i]);
      end
      if (i < 2) tick();
    end
    bus.mode_i = 1'b0;
    tick();
    bus.mode_i = 1'b1; bus.e_i = 3'b101; bus.a_i = 3'd5; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    vectors++;
    if ({bus.o_o, bus.idx_o, bus.busy_o} !== {pol(8'h00), 3'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL start_disabled: o=%h idx=%0d busy=%b, want o=%h idx=1 busy=0",
               bus.o_o, bus.idx_o, bus.busy_o, pol(8'h00));
    end
    bus.mode_i = 1'b0; bus.e_i = 3'b100; bus.a_i = 3'd2; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    vectors++;
    if ({bus.o_o, bus.idx_o, bus.busy_o} !== {pol(8'h04), 3'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL start_mode0: o=%h idx=%0d busy=%b, want o=%h idx=2 busy=0",
               bus.o_o, bus.idx_o, bus.busy_o, pol(8'h04));
    end
    bus.mode_i = 1'b1; bus.a_i = 3'd0; bus.dwell_i = 8'hFF; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (255) tick();
    vectors++;
    if ({bus.o_o, bus.idx_o} !== {pol(8'h01), 3'd0}) begin
      miscompares++;
      $display("FAIL dwell_max_hold: o=%h idx=%0d, want o=%h idx=0", bus.o_o, bus.idx_o, pol(8'h01));
    end
    tick();
    vectors++;
    if ({bus.o_o, bus.idx_o} !== {pol(8'h02), 3'd1}) begin
      miscompares++;
      $display("FAIL dwell_max_step: o=%h idx=%0d, want o=%h idx=1", bus.o_o, bus.idx_o, pol(8'h02));
    end
    bus.mode_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_wrap();
    test_pause_stop();
    test_reset_mid_scan();
    test_edge_cases();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
